ddc_cfg_sequencer: RTL



---
 rtl/ddc_seq_pkg.sv | 17 +
 rtl/ddc_cfg_sequencer_table.sv | 35 +++
 rtl/ddc_cfg_sequencer.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/ddc_seq_pkg.sv
// Shared types for the DDC configuration sequencer.
package ddc_seq_pkg;
    localparam int DDC_PH_W = 20;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RESYNC,
        S_FLUSH,
        S_RUN
    } ddc_seq_state_e;

    typedef struct packed {
        logic [DDC_PH_W-1:0] pinc;
        logic [DDC_PH_W-1:0] poff;
    } ddc_ch_cfg_t;
endpackage

// File: rtl/ddc_cfg_sequencer_table.sv
// Shadow table of per-channel pinc/poff: one write port, async read.
module ddc_cfg_table
    import ddc_seq_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int PH_W   = DDC_PH_W
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      we_i,
    input  logic [$clog2(NUM_CH)-1:0] wch_i,
    input  logic [PH_W-1:0]           pinc_i,
    input  logic [PH_W-1:0]           poff_i,
    input  logic [$clog2(NUM_CH)-1:0] rch_i,
    output logic [PH_W-1:0]           pinc_o,
    output logic [PH_W-1:0]           poff_o
);
    logic [PH_W-1:0] pinc_q [NUM_CH];
    logic [PH_W-1:0] poff_q [NUM_CH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < NUM_CH; i++) begin
                pinc_q[i] <= '0;
                poff_q[i] <= '0;
            end
        end else if (we_i) begin
            pinc_q[wch_i] <= pinc_i;
            poff_q[wch_i] <= poff_i;
        end
    end

    assign pinc_o = pinc_q[rch_i];
    assign poff_o = poff_q[rch_i];
endmodule

// File: rtl/ddc_cfg_sequencer.sv
// Loads the DDC channel table, resyncs, flushes, then asserts run.
// Optional RESYNC state: define DDC_SEQ_RESYNC_EN.
module ddc_cfg_sequencer
    import ddc_seq_pkg::*;
#(
    parameter int NUM_CH       = 4,
    parameter int PH_W         = DDC_PH_W,
    parameter int FLUSH_BLOCKS = 4,
    parameter int ACK_TIMEOUT  = 255
) (
    input  logic                      dev_clk,
    input  logic                      dev_rst,
    input  logic                      tbl_wr,
    input  logic [$clog2(NUM_CH)-1:0] tbl_ch,
    input  logic [PH_W-1:0]           tbl_pinc,
    input  logic [PH_W-1:0]           tbl_poff,
    input  logic [15:0]               ds_rate,
    input  logic                      start,
    input  logic                      stop,
    output logic [$clog2(NUM_CH)-1:0] ddc_ch,
    output logic [PH_W-1:0]           ddc_pinc,
    output logic [PH_W-1:0]           ddc_poff,
    output logic                      ddc_we,
    input  logic                      ddc_ack,
    output logic                      resync,
    output logic                      run,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);
    localparam int CH_W  = $clog2(NUM_CH);
    localparam int TO_W  = $clog2(ACK_TIMEOUT + 1);
    localparam int CNT_W = 24;
    localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
    localparam bit CH_SPARSE = (2 ** CH_W) != NUM_CH;

    ddc_seq_state_e   state_q;
    logic [CH_W-1:0]  idx_q;
    logic [TO_W-1:0]  tmo_q;
    logic [CNT_W-1:0] cnt_q;
    logic [15:0]      ds_q;
    logic [CH_W-1:0]  ch_q;
    logic [PH_W-1:0]  pinc_q;
    logic [PH_W-1:0]  poff_q;
    logic             we_q;
    logic             resync_q;
    logic             run_q;
    logic             busy_q;
    logic             done_q;
    logic             err_q;

    logic             tbl_open;
    logic             ch_bad;
    logic             wr_ok;
    logic             wr_bad;
    logic [CH_W-1:0]  rd_ch;
    logic [PH_W-1:0]  rd_pinc;
    logic [PH_W-1:0]  rd_poff;
    logic [CNT_W-1:0] flush_init;

    assign tbl_open   = (state_q == S_IDLE) || (state_q == S_RUN);
    assign ch_bad     = CH_SPARSE && (32'(tbl_ch) >= NUM_CH);
    assign wr_ok      = tbl_wr && tbl_open && !ch_bad;
    assign wr_bad     = tbl_wr && !(tbl_open && !ch_bad);
    assign flush_init = CNT_W'(FLUSH_BLOCKS) * CNT_W'(ds_q) - CNT_W'(1);
    // Outside LOAD the only read needed is channel 0 for an upcoming start.
    assign rd_ch      = (state_q == S_LOAD) ? idx_q + 1'b1 : '0;

    ddc_cfg_table #(
        .NUM_CH (NUM_CH),
        .PH_W   (PH_W)
    ) u_table (
        .clk_i  (dev_clk),
        .rst_i  (dev_rst),
        .we_i   (wr_ok),
        .wch_i  (tbl_ch),
        .pinc_i (tbl_pinc),
        .poff_i (tbl_poff),
        .rch_i  (rd_ch),
        .pinc_o (rd_pinc),
        .poff_o (rd_poff)
    );

    always_ff @(posedge dev_clk) begin
        if (dev_rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            tmo_q    <= '0;
            cnt_q    <= '0;
            ds_q     <= 16'd1;
            ch_q     <= '0;
            pinc_q   <= '0;
            poff_q   <= '0;
            we_q     <= 1'b0;
            resync_q <= 1'b0;
            run_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            done_q   <= 1'b0;
            resync_q <= 1'b0;
            if (wr_bad) err_q <= 1'b1;
            if (stop) begin
                state_q <= S_IDLE;
                we_q    <= 1'b0;
                run_q   <= 1'b0;
                busy_q  <= 1'b0;
            end else begin
                unique case (state_q)
                    S_IDLE, S_RUN: begin
                        if (start) begin
                            state_q <= S_LOAD;
                            idx_q   <= '0;
                            tmo_q   <= '0;
                            ds_q    <= (ds_rate == '0) ? 16'd1 : ds_rate;
                            ch_q    <= '0;
                            pinc_q  <= rd_pinc;
                            poff_q  <= rd_poff;
                            we_q    <= 1'b1;
                            run_q   <= 1'b0;
                            busy_q  <= 1'b1;
                            err_q   <= wr_bad;
                        end
                    end
                    S_LOAD: begin
                        if (ddc_ack) begin
                            tmo_q <= '0;
                            if (idx_q == LAST_CH) begin
                                we_q <= 1'b0;
`ifdef DDC_SEQ_RESYNC_EN
                                state_q  <= S_RESYNC;
                                resync_q <= 1'b1;
`else
                                state_q <= S_FLUSH;
                                cnt_q   <= flush_init;
`endif
                            end else begin
                                idx_q  <= idx_q + 1'b1;
                                ch_q   <= idx_q + 1'b1;
                                pinc_q <= rd_pinc;
                                poff_q <= rd_poff;
                            end
                        end else if (tmo_q == TO_LAST) begin
                            state_q <= S_IDLE;
                            we_q    <= 1'b0;
                            busy_q  <= 1'b0;
                            err_q   <= 1'b1;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                    S_RESYNC: begin
                        state_q <= S_FLUSH;
                        cnt_q   <= flush_init;
                    end
                    S_FLUSH: begin
                        if (cnt_q == '0) begin
                            state_q <= S_RUN;
                            run_q   <= 1'b1;
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                        end else begin
                            cnt_q <= cnt_q - 1'b1;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign ddc_ch   = ch_q;
    assign ddc_pinc = pinc_q;
    assign ddc_poff = poff_q;
    assign ddc_we   = we_q;
    assign resync   = resync_q;
    assign run      = run_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err      = err_q;
endmodule
